alu_iter_comparator: RTL and testbench

//  Parametrised, multi-cycle magnitude comparator for the RV32IM ALU/branch path.

---
 rtl/alu_iter_comparator.sv | 167 ++++++++++++++++
 tb/tb_alu_iter_comparator.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_iter_comparator.sv
// alu_iter_comparator
//   Multi-cycle magnitude comparator for the ALU/branch path. Operands are
//   compared CHUNK_WIDTH bits per cycle, starting with the most significant
//   chunk. The compare stops at the first chunk that differs. Signed compares
//   flip the operand MSBs on accept, so the datapath only ever does an
//   unsigned compare.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   in_valid / in_ready      request handshake (in_ready only in IDLE)
//   signed_mode, operand_A/B sampled on accept
//   flush                    synchronous abort; wins over any handshake
//   out_valid / out_ready    result handshake (DONE holds until taken)
//   greater, equal, less     one-hot result, zero outside DONE
//   busy                     state != IDLE
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for a request, in_ready=1
// CMP   | comparing chunk r_idx, moving from MSB chunk toward LSB chunk
// DONE  | result flags valid, waiting for out_ready
module alu_iter_comparator #(
  parameter int DATA_WIDTH  = 32,
  parameter int CHUNK_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  signed_mode,
  input  logic [DATA_WIDTH-1:0] operand_A,
  input  logic [DATA_WIDTH-1:0] operand_B,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  greater,
  output logic                  equal,
  output logic                  less,
  output logic                  busy
);

  localparam int NCH  = DATA_WIDTH / CHUNK_WIDTH;
  localparam int IDXW = (NCH > 1) ? $clog2(NCH) : 1;

  generate
    if (DATA_WIDTH % CHUNK_WIDTH != 0) begin : g_bad_cfg
      $error("alu_iter_comparator: DATA_WIDTH must be a multiple of CHUNK_WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMP  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [DATA_WIDTH-1:0]   r_a;
  logic [DATA_WIDTH-1:0]   r_b;
  logic [IDXW-1:0]         r_idx;
  logic                    r_gt;
  logic                    r_eq;
  logic                    r_lt;

  logic                    w_accept;
  logic                    w_done_hs;
  logic [DATA_WIDTH-1:0]   w_bias;
  logic [CHUNK_WIDTH-1:0]  w_chunk_a;
  logic [CHUNK_WIDTH-1:0]  w_chunk_b;
  logic                    w_differ;
  logic                    w_last;

  // Flipping the sign bit maps two's-complement order onto unsigned order.
  assign w_bias    = {signed_mode, {(DATA_WIDTH-1){1'b0}}};
  assign w_accept  = (r_state == S_IDLE) && in_valid && !flush;
  assign w_done_hs = (r_state == S_DONE) && out_ready;

  assign w_chunk_a = r_a[r_idx*CHUNK_WIDTH +: CHUNK_WIDTH];
  assign w_chunk_b = r_b[r_idx*CHUNK_WIDTH +: CHUNK_WIDTH];
  assign w_differ  = (w_chunk_a != w_chunk_b);
  assign w_last    = (r_idx == '0);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (w_accept) w_state_nxt = S_CMP;
        S_CMP:   if (w_differ || w_last) w_state_nxt = S_DONE;
        S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Output logic; in_ready is held low while reset is asserted.
  always_comb begin
    in_ready  = (r_state == S_IDLE) && !rst;
    out_valid = (r_state == S_DONE);
    busy      = (r_state != S_IDLE);
  end

  assign greater = r_gt;
  assign equal   = r_eq;
  assign less    = r_lt;

  // Operand, index and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a   <= '0;
      r_b   <= '0;
      r_idx <= '0;
      r_gt  <= 1'b0;
      r_eq  <= 1'b0;
      r_lt  <= 1'b0;
    end else if (flush) begin
      r_gt  <= 1'b0;
      r_eq  <= 1'b0;
      r_lt  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_a   <= operand_A ^ w_bias;
            r_b   <= operand_B ^ w_bias;
            r_idx <= IDXW'(NCH - 1);
          end
        end
        S_CMP: begin
          if (w_differ) begin
            r_gt <= (w_chunk_a > w_chunk_b);
            r_lt <= (w_chunk_a < w_chunk_b);
          end else if (w_last) begin
            r_eq <= 1'b1;
          end else begin
            r_idx <= r_idx - 1'b1;
          end
        end
        S_DONE: begin
          if (w_done_hs) begin
            r_gt <= 1'b0;
            r_eq <= 1'b0;
            r_lt <= 1'b0;
          end
        end
        default: begin
          r_gt <= 1'b0;
          r_eq <= 1'b0;
          r_lt <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_iter_comparator.sv
// tb_alu_iter_comparator
//   Four comparator instances (CHUNK_WIDTH 32/8/4/1) share operands, mode,
//   flush and reset; each has its own handshake signals. Instance 1
//   (CHUNK_WIDTH=8) carries the directed latency/handshake tests. All
//   instances then run a random phase with valid/ready stalls against a
//   signed/unsigned reference compare.
module tb_alu_iter_comparator;

  localparam int M = 1;  // index of the CHUNK_WIDTH=8 instance

  logic        clk;
  logic        rst;
  logic [31:0] opa;
  logic [31:0] opb;
  logic        smode;
  logic        flush;
  logic [3:0]  iv;
  logic [3:0]  ordy;
  wire  [3:0]  ir;
  wire  [3:0]  ov;
  wire  [3:0]  gt;
  wire  [3:0]  eq;
  wire  [3:0]  lt;
  wire  [3:0]  bsy;

  int n_checks = 0;
  int n_errors = 0;

  alu_iter_comparator #(.DATA_WIDTH(32), .CHUNK_WIDTH(32)) u_cw32 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .signed_mode(smode),
    .operand_A(opa), .operand_B(opb), .flush(flush), .out_valid(ov[0]),
    .out_ready(ordy[0]), .greater(gt[0]), .equal(eq[0]), .less(lt[0]), .busy(bsy[0]));

  alu_iter_comparator #(.DATA_WIDTH(32), .CHUNK_WIDTH(8)) u_cw8 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .signed_mode(smode),
    .operand_A(opa), .operand_B(opb), .flush(flush), .out_valid(ov[1]),
    .out_ready(ordy[1]), .greater(gt[1]), .equal(eq[1]), .less(lt[1]), .busy(bsy[1]));

  alu_iter_comparator #(.DATA_WIDTH(32), .CHUNK_WIDTH(4)) u_cw4 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .signed_mode(smode),
    .operand_A(opa), .operand_B(opb), .flush(flush), .out_valid(ov[2]),
    .out_ready(ordy[2]), .greater(gt[2]), .equal(eq[2]), .less(lt[2]), .busy(bsy[2]));

  alu_iter_comparator #(.DATA_WIDTH(32), .CHUNK_WIDTH(1)) u_cw1 (
    .clk(clk), .rst(rst), .in_valid(iv[3]), .in_ready(ir[3]), .signed_mode(smode),
    .operand_A(opa), .operand_B(opb), .flush(flush), .out_valid(ov[3]),
    .out_ready(ordy[3]), .greater(gt[3]), .equal(eq[3]), .less(lt[3]), .busy(bsy[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #20ms;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] ref_cmp(input logic [31:0] a, input logic [31:0] b, input logic sm);
    logic gtr, lss;
    if (sm) begin
      gtr = $signed(a) > $signed(b);
      lss = $signed(a) < $signed(b);
    end else begin
      gtr = a > b;
      lss = a < b;
    end
    return {gtr, (a == b), lss};
  endfunction

  // One operation on instance M with out_ready=1. lat counts rising edges
  // after the accepting edge up to the one after which out_valid shows.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sm,
                        output int lat, output logic [2:0] res);
    @(negedge clk);
    opa = a; opb = b; smode = sm; iv[M] = 1'b1; ordy[M] = 1'b1;
    @(posedge clk); #1;
    iv[M] = 1'b0;
    lat = 0;
    while (!ov[M] && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    res = {gt[M], eq[M], lt[M]};
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sm;
    int          lat;
    logic [2:0]  res;
    string       tag;
  } vec_t;

  initial begin
    vec_t vecs[$];
    int lat;
    logic [2:0] res;
    bit seen;

    rst = 1'b1; flush = 1'b0; iv = '0; ordy = '1;
    opa = '0; opb = '0; smode = 1'b0;

    // Reset state
    #13;
    check_eq("rst_in_ready", ir, 4'h0);
    check_eq("rst_out_valid", ov, 4'h0);
    check_eq("rst_busy", bsy, 4'h0);
    check_eq("rst_flags", {gt, eq, lt}, 12'h0);
    @(negedge clk); rst = 1'b0;
    #1;
    check_eq("post_rst_in_ready", ir, 4'hF);

    // Directed vectors: {gt,eq,lt} and latency
    vecs.push_back('{32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1, 3'b001, "neg1_vs_1_s"});
    vecs.push_back('{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1, 3'b100, "max_vs_1_u"});
    vecs.push_back('{32'h1234_5678, 32'h1234_5678, 1'b0, 4, 3'b010, "equal_u"});
    vecs.push_back('{32'h1234_5678, 32'h1234_5678, 1'b1, 4, 3'b010, "equal_s"});
    vecs.push_back('{32'h1235_5678, 32'h1234_5678, 1'b0, 2, 3'b100, "chunk2_gt"});
    vecs.push_back('{32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 1, 3'b001, "minint_s"});
    vecs.push_back('{32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1, 3'b100, "minint_u"});
    vecs.push_back('{32'h0000_0010, 32'h0000_0020, 1'b0, 4, 3'b001, "lsb_chunk_lt"});
    vecs.push_back('{32'hAB12_0000, 32'hAB13_0000, 1'b1, 2, 3'b001, "chunk2_lt_s"});
    vecs.push_back('{32'hFF00_0080, 32'hFF00_0070, 1'b1, 4, 3'b100, "neg_lsb_gt_s"});
    foreach (vecs[k]) begin
      run_op(vecs[k].a, vecs[k].b, vecs[k].sm, lat, res);
      check_eq({vecs[k].tag, "_res"}, res, vecs[k].res);
      check_eq({vecs[k].tag, "_lat"}, lat, vecs[k].lat);
      check_eq({vecs[k].tag, "_idle"}, {ir[M], bsy[M], ov[M]}, 3'b100);
    end

    // Backpressure: 5 stalled cycles in DONE
    @(negedge clk);
    opa = 32'd5; opb = 32'd3; smode = 1'b0; iv[M] = 1'b1; ordy[M] = 1'b0;
    @(posedge clk); #1;
    iv[M] = 1'b0;
    lat = 0;
    while (!ov[M] && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check_eq("bp_lat", lat, 4);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check_eq("bp_hold", {ov[M], gt[M], eq[M], lt[M], ir[M], bsy[M]}, 6'b110001);
    end
    @(negedge clk); ordy[M] = 1'b1;
    @(posedge clk); #1;
    check_eq("bp_release", {ov[M], gt[M], eq[M], lt[M], ir[M], bsy[M]}, 6'b000010);

    // Flush on the second CMP cycle of an equal compare
    @(negedge clk);
    opa = 32'h1234_5678; opb = 32'h1234_5678; smode = 1'b0; iv[M] = 1'b1;
    @(posedge clk); #1;
    iv[M] = 1'b0;
    @(posedge clk); #1;
    check_eq("flush_pre_busy", bsy[M], 1'b1);
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check_eq("flush_idle", {ov[M], ir[M], bsy[M], gt[M], eq[M], lt[M]}, 6'b010000);
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (ov[M]) seen = 1'b1;
    end
    check_eq("flush_no_result", seen, 1'b0);

    // Flush wins over a simultaneous accept
    @(negedge clk); iv[M] = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    iv[M] = 1'b0; flush = 1'b0;
    check_eq("flush_vs_accept", {bsy[M], ir[M]}, 2'b01);

    // Flush drops a pending result in DONE
    @(negedge clk);
    opa = 32'h9000_0000; opb = 32'h1000_0000; smode = 1'b1; iv[M] = 1'b1; ordy[M] = 1'b0;
    @(posedge clk); #1;
    iv[M] = 1'b0;
    @(posedge clk); #1;
    check_eq("flush_done_pre", {ov[M], gt[M], eq[M], lt[M]}, 4'b1001);
    @(negedge clk); flush = 1'b1; ordy[M] = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check_eq("flush_done_post", {ov[M], gt[M], eq[M], lt[M], ir[M]}, 5'b00001);

    // Reset in the middle of CMP
    @(negedge clk);
    opa = 32'hCAFE_F00D; opb = 32'hCAFE_F00D; smode = 1'b0; iv[M] = 1'b1;
    @(posedge clk); #1;
    iv[M] = 1'b0;
    @(posedge clk); #1;
    check_eq("rst_mid_pre_busy", bsy[M], 1'b1);
    #2 rst = 1'b1;
    #1;
    check_eq("rst_mid_outputs", {ov[M], bsy[M], ir[M], gt[M], eq[M], lt[M]}, 6'b000000);
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    #1;
    check_eq("rst_mid_release", ir[M], 1'b1);
    run_op(32'h0000_0010, 32'h0000_0020, 1'b0, lat, res);
    check_eq("rst_mid_new_res", res, 3'b001);
    check_eq("rst_mid_new_lat", lat, 4);

    // Random phase on all four instances
    ordy = '1;
    @(negedge clk);
    for (int op = 0; op < 1500; op++) begin
      logic [3:0]  pend_acc, pend_res;
      logic [31:0] a, b;
      logic        sm, inv_ok;
      int          cyc;
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = a;
        1:       b = $urandom;
        2:       b = a ^ (32'h1 << $urandom_range(0, 31));
        default: b = (a & 32'hFFFF_0000) | ($urandom & 32'h0000_FFFF);
      endcase
      sm = $urandom_range(0, 1) == 1;
      opa = a; opb = b; smode = sm;
      pend_acc = '1; pend_res = '1; cyc = 0;
      while (pend_res != '0 && cyc < 400) begin
        for (int i = 0; i < 4; i++) begin
          iv[i]   = pend_acc[i] && ($urandom_range(0, 3) != 0);
          ordy[i] = $urandom_range(0, 2) != 0;
        end
        #1;
        for (int i = 0; i < 4; i++) begin
          inv_ok = ov[i] ? $onehot({gt[i], eq[i], lt[i]}) : ({gt[i], eq[i], lt[i]} == 3'b000);
          check_eq($sformatf("flag_inv[%0d]", i), inv_ok, 1'b1);
          if (iv[i] && ir[i]) pend_acc[i] = 1'b0;
          if (ov[i] && ordy[i]) begin
            check_eq($sformatf("rand_res[%0d] a=%h b=%h s=%0d", i, a, b, sm),
                     {gt[i], eq[i], lt[i]}, ref_cmp(a, b, sm));
            pend_res[i] = 1'b0;
          end
        end
        @(negedge clk);
        cyc++;
      end
      iv = '0;
      check_eq("rand_timeout", pend_res, 4'h0);
      if (pend_res != '0) break;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
